// File: rtl/interrupt_cp0_pkg.sv
// ---------------------------------------------------------------------------
// interrupt_cp0_pkg
// Shared CP0 definitions for the interrupt block: register numbers, the bit
// positions inside Status and Cause, and a helper that assembles the visible
// Status word from its stored fields.
// ---------------------------------------------------------------------------
package interrupt_cp0_pkg;

   // CP0 register numbers (the rd field of mtc0/mfc0)
   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   // Status bit positions
   localparam int STATUS_IE  = 0;
   localparam int STATUS_EXL = 1;
   localparam int IM_LO      = 8;
   localparam int IM_HI      = 15;

   // Cause bit position of the timer request line
   localparam int CAUSE_IP7  = 15;

   // Only IM, EXL and IE exist in hardware; every other Status bit reads 0.
   function automatic logic [31:0] statusWord(input logic [7:0] im,
                                              input logic       exl,
                                              input logic       ie);
      logic [31:0] w;
      w                = 32'h0;
      w[IM_HI:IM_LO]   = im;
      w[STATUS_EXL]    = exl;
      w[STATUS_IE]     = ie;
      return w;
   endfunction

endpackage

// File: rtl/interrupt_cp0_reg.sv
// ---------------------------------------------------------------------------
// cp0_reg
// Parameterised-width register with load enable, asynchronous active-low
// reset and a configurable reset value. Used for every stored CP0 field.
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   i_en    in   load enable
//   i_d     in   next value, captured when i_en = 1
//   o_q     out  current contents
// ---------------------------------------------------------------------------
module cp0_reg #(
   parameter int                WIDTH     = 32,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Hold the value until enabled; reset asynchronously to RESET_VAL.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_q <= RESET_VAL;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/interrupt_cp0.sv
// ---------------------------------------------------------------------------
// interrupt_cp0
// Coprocessor-0 interrupt block. Holds Status (IM/EXL/IE), EPC and a live
// Cause view of the timer request, and decides when an interrupt is taken.
//
// Ports:
//   clock           in   rising-edge clock
//   reset           in   asynchronous active-low reset
//   TimerInterrupt  in   level request from the timer (IP7)
//   regnum          in   CP0 register number for mtc0/mfc0
//   wr_data         in   mtc0 write data
//   MTC0            in   write enable for register regnum
//   ERET            in   current instruction is eret
//   next_pc         in   resume PC saved into EPC when an interrupt is taken
//   rd_data         out  mfc0 read data (combinational)
//   EPC             out  current EPC contents
//   TakenInterrupt  out  interrupt taken this cycle
// ---------------------------------------------------------------------------
module interrupt_cp0
   import interrupt_cp0_pkg::*;
#(
   parameter logic [31:0] RESET_EPC = 32'h0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        TimerInterrupt,
   input  logic [4:0]  regnum,
   input  logic [31:0] wr_data,
   input  logic        MTC0,
   input  logic        ERET,
   input  logic [31:0] next_pc,
   output logic [31:0] rd_data,
   output logic [31:0] EPC,
   output logic        TakenInterrupt
);

   logic [7:0]  w_im;
   logic        w_ie;
   logic        w_exl;
   logic [31:0] w_epc;
   logic [31:0] w_status;
   logic [31:0] w_cause;
   logic        w_taken;
   logic        w_wrStatus;
   logic        w_wrEpc;
   logic        w_epcEn;
   logic [31:0] w_epcD;
   logic        w_exlEn;
   logic        w_exlD;

   // Cause is not stored: IP7 mirrors the timer line, everything else is 0.
   always_comb begin
      w_cause            = 32'h0;
      w_cause[CAUSE_IP7] = TimerInterrupt;
   end

   assign w_status = statusWord(w_im, w_exl, w_ie);

   // An interrupt is taken when any unmasked pending line is set, interrupts
   // are enabled and we are not already inside a handler. Because EXL is set
   // on the taking edge, this is high for exactly one cycle per entry.
   assign w_taken = (|(w_cause[IM_HI:IM_LO] & w_im)) & w_ie & ~w_exl;

   assign w_wrStatus = MTC0 && (regnum == CP0_STATUS);
   assign w_wrEpc    = MTC0 && (regnum == CP0_EPC);

   // EPC: the taking edge saves next_pc and overrides any mtc0 to EPC.
   assign w_epcEn = w_taken | w_wrEpc;
   assign w_epcD  = w_taken ? next_pc : wr_data;

   // EXL: taking forces 1, eret forces 0 (even against an mtc0 Status write),
   // otherwise an mtc0 Status write loads it. ERET and taking cannot coincide
   // since taking requires EXL = 0.
   assign w_exlEn = w_taken | ERET | w_wrStatus;
   always_comb begin
      w_exlD = wr_data[STATUS_EXL];
      if (w_taken) begin
         w_exlD = 1'b1;
      end else if (ERET) begin
         w_exlD = 1'b0;
      end
   end

   cp0_reg #(.WIDTH(32), .RESET_VAL(RESET_EPC)) uEpc (
      .clock (clock),
      .reset (reset),
      .i_en  (w_epcEn),
      .i_d   (w_epcD),
      .o_q   (w_epc)
   );

   cp0_reg #(.WIDTH(8), .RESET_VAL(8'h00)) uIm (
      .clock (clock),
      .reset (reset),
      .i_en  (w_wrStatus),
      .i_d   (wr_data[IM_HI:IM_LO]),
      .o_q   (w_im)
   );

   cp0_reg #(.WIDTH(1), .RESET_VAL(1'b0)) uIe (
      .clock (clock),
      .reset (reset),
      .i_en  (w_wrStatus),
      .i_d   (wr_data[STATUS_IE]),
      .o_q   (w_ie)
   );

   cp0_reg #(.WIDTH(1), .RESET_VAL(1'b0)) uExl (
      .clock (clock),
      .reset (reset),
      .i_en  (w_exlEn),
      .i_d   (w_exlD),
      .o_q   (w_exl)
   );

   // mfc0 read mux; unimplemented register numbers read 0.
   always_comb begin
      rd_data = 32'h0;
      case (regnum)
         CP0_STATUS: rd_data = w_status;
         CP0_CAUSE:  rd_data = w_cause;
         CP0_EPC:    rd_data = w_epc;
         default:    rd_data = 32'h0;
      endcase
   end

   assign EPC            = w_epc;
   assign TakenInterrupt = w_taken;

endmodule

// File: tb/tb_interrupt_cp0.sv
// ---------------------------------------------------------------------------
// tb_interrupt_cp0
// Directed bench for interrupt_cp0. Each stimulus cycle drives the inputs
// just after the rising edge and pushes its hand-computed expectations into
// a queue; the monitor drains the queue on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_interrupt_cp0;

   localparam int KIND_TAKEN = 0;
   localparam int KIND_RD    = 1;
   localparam int KIND_EPC   = 2;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] value;
   } expect_t;

   logic        clock;
   logic        reset;
   logic        TimerInterrupt;
   logic [4:0]  regnum;
   logic [31:0] wr_data;
   logic        MTC0;
   logic        ERET;
   logic [31:0] next_pc;
   logic [31:0] rd_data;
   logic [31:0] EPC;
   logic        TakenInterrupt;

   expect_t expectQ[$];
   int      checkCount = 0;
   int      failCount  = 0;

   interrupt_cp0 #(.RESET_EPC(32'h0)) dut (
      .clock          (clock),
      .reset          (reset),
      .TimerInterrupt (TimerInterrupt),
      .regnum         (regnum),
      .wr_data        (wr_data),
      .MTC0           (MTC0),
      .ERET           (ERET),
      .next_pc        (next_pc),
      .rd_data        (rd_data),
      .EPC            (EPC),
      .TakenInterrupt (TakenInterrupt)
   );

   // Clock starts high so the first falling edge precedes the first rising edge.
   initial begin
      clock = 1'b1;
      forever #5 clock = ~clock;
   end

   // Compare one queued expectation against the output it names.
   task automatic checkOutput(input expect_t e);
      logic [31:0] actual;
      case (e.kind)
         KIND_TAKEN: actual = {31'b0, TakenInterrupt};
         KIND_RD:    actual = rd_data;
         default:    actual = EPC;
      endcase
      checkCount++;
      if (actual !== e.value) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", e.name, actual, e.value, $time);
      end
   endtask

   // Monitor: everything expected for this cycle is checked mid-cycle.
   always @(negedge clock) begin
      while (expectQ.size() > 0) begin
         checkOutput(expectQ.pop_front());
      end
   end

   task automatic applyStimulus(input logic ti, input logic mtc0, input logic eret,
                                input logic [4:0] rn, input logic [31:0] wd,
                                input logic [31:0] npc);
      TimerInterrupt = ti;
      MTC0           = mtc0;
      ERET           = eret;
      regnum         = rn;
      wr_data        = wd;
      next_pc        = npc;
   endtask

   task automatic expectVal(input string name, input int kind, input logic [31:0] value);
      expect_t e;
      e.name  = name;
      e.kind  = kind;
      e.value = value;
      expectQ.push_back(e);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Watchdog so the bench always terminates.
   initial begin
      #20000;
      $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // Reset held with the timer requesting
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0);
      expectVal("reset_taken", KIND_TAKEN, 32'h0);
      expectVal("reset_status", KIND_RD, 32'h0);
      expectVal("reset_epc", KIND_EPC, 32'h0);
      tick();

      // Basic take: enable IM7 and IE, then raise the timer
      reset = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd12, 32'h0000_8001, 32'h0);
      expectVal("pre_enable_taken", KIND_TAKEN, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0040_0024);
      expectVal("basic_taken", KIND_TAKEN, 32'h1);
      expectVal("basic_status_before", KIND_RD, 32'h0000_8001);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0040_0030);
      expectVal("basic_one_cycle", KIND_TAKEN, 32'h0);
      expectVal("basic_status_after", KIND_RD, 32'h0000_8003);
      expectVal("basic_epc", KIND_EPC, 32'h0040_0024);
      tick();

      // Masking: IM = 0 with IE = 1
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_0001, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd13, 32'h0, 32'h0);
      expectVal("mask_im_taken", KIND_TAKEN, 32'h0);
      expectVal("mask_cause", KIND_RD, 32'h0000_8000);
      tick();
      // Masking: IM7 = 1 with IE = 0
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd12, 32'h0000_8000, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0);
      expectVal("mask_ie_taken", KIND_TAKEN, 32'h0);
      expectVal("mask_ie_status", KIND_RD, 32'h0000_8000);
      tick();

      // Eret re-entry
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd12, 32'h0000_8001, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0000_0100);
      expectVal("reentry_first_take", KIND_TAKEN, 32'h1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b1, 5'd12, 32'h0, 32'h0000_0104);
      expectVal("reentry_in_handler", KIND_TAKEN, 32'h0);
      expectVal("reentry_exl_set", KIND_RD, 32'h0000_8003);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0000_0200);
      expectVal("reentry_exl_clear", KIND_RD, 32'h0000_8001);
      expectVal("reentry_retake", KIND_TAKEN, 32'h1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd14, 32'h0, 32'h0);
      expectVal("reentry_epc", KIND_EPC, 32'h0000_0200);
      expectVal("reentry_rd_epc", KIND_RD, 32'h0000_0200);
      tick();

      // Collision: mtc0 EPC on the taking edge
      applyStimulus(1'b0, 1'b0, 1'b1, 5'd12, 32'h0, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd14, 32'hDEAD_BEEF, 32'h0000_0300);
      expectVal("col_epc_taken", KIND_TAKEN, 32'h1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd14, 32'h0, 32'h0);
      expectVal("col_epc_value", KIND_EPC, 32'h0000_0300);
      tick();

      // Collision: mtc0 Status clearing EXL on the taking edge
      applyStimulus(1'b0, 1'b0, 1'b1, 5'd12, 32'h0, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_FF01, 32'h0000_0400);
      expectVal("col_status_taken", KIND_TAKEN, 32'h1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0);
      expectVal("col_status_value", KIND_RD, 32'h0000_FF03);
      expectVal("col_status_epc", KIND_EPC, 32'h0000_0400);
      tick();

      // ERET and mtc0 Status on the same edge: ERET wins on EXL
      applyStimulus(1'b0, 1'b1, 1'b1, 5'd12, 32'h0000_FF03, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0);
      expectVal("eret_vs_mtc0", KIND_RD, 32'h0000_FF01);
      tick();

      // Unused registers ignore writes
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd13, 32'hFFFF_FFFF, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd5, 32'hFFFF_FFFF, 32'h0);
      expectVal("unused_rd5", KIND_RD, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0);
      expectVal("unused_status_kept", KIND_RD, 32'h0000_FF01);
      expectVal("unused_epc_kept", KIND_EPC, 32'h0000_0400);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd13, 32'h0, 32'h0);
      expectVal("unused_cause_idle", KIND_RD, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd12, 32'hFFFF_FFFF, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0);
      expectVal("status_all_ones", KIND_RD, 32'h0000_FF03);
      tick();

      // Async reset mid-handler
      applyStimulus(1'b0, 1'b0, 1'b1, 5'd12, 32'h0, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0000_0500);
      expectVal("pre_reset_take", KIND_TAKEN, 32'h1);
      tick();
      reset = 1'b0;
      expectVal("midreset_taken", KIND_TAKEN, 32'h0);
      expectVal("midreset_status", KIND_RD, 32'h0);
      expectVal("midreset_epc", KIND_EPC, 32'h0);
      tick();
      reset = 1'b1;
      tick();

      // Any expectation still queued means the monitor never saw it.
      if (expectQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expectQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/interrupt_cp0.md
# interrupt_cp0

Coprocessor-0 interrupt block sitting directly downstream of the memory-mapped timer: consumes `TimerInterrupt`, holds the Status, Cause and EPC registers, and decides when the processor takes an interrupt. It drives `TakenInterrupt` to the PC-select logic, supplies `EPC` for `eret`, and returns register contents for `mfc0`. Software writes it through `mtc0` from the decode/writeback path of the single-cycle datapath.

## Interface
Parameters:
- `RESET_EPC`, 32'h0, EPC value after reset.

Ports:
- `clock`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low; asserted (0) forces all state to reset values immediately.
- `TimerInterrupt`  input  1  level request from the timer; stays high until software acknowledges it at the timer.
- `regnum`  input  5  CP0 register number for `mtc0`/`mfc0` (instruction rd field).
- `wr_data`  input  32  `mtc0` write data (rt value).
- `MTC0`  input  1  write enable for register `regnum`.
- `ERET`  input  1  current instruction is `eret`.
- `next_pc`  input  32  PC of the instruction to resume at if an interrupt is taken this cycle.
- `rd_data`  output  32  `mfc0` read data for `regnum`, combinational.
- `EPC`  output  32  current EPC contents.
- `TakenInterrupt`  output  1  interrupt taken this cycle; PC mux selects the handler.

## Operation
- Registers: Status = 12, Cause = 13, EPC = 14. Other numbers read 0 and ignore writes.
- Status: bits [15:8] IM (mask), bit 1 EXL, bit 0 IE. Only these 10 bits are stored; other bits read 0.
- Cause: read-only and not stored. It reads {16'b0, TimerInterrupt, 15'b0}, i.e. IP7 at bit 15, live. ExcCode [6:2] is always 0. `mtc0` to Cause is ignored.
- EPC: 32-bit, fully writable by `mtc0`.
- `TakenInterrupt` = (Cause[15:8] & Status[15:8]) != 0 && Status.IE && !Status.EXL. It is combinational and depends only on current state and `TimerInterrupt`.
- On an edge with `TakenInterrupt` = 1:
  - EPC <= `next_pc`.
  - Status.EXL <= 1.
- On an edge with `ERET` = 1: Status.EXL <= 0.
- On an edge with `MTC0` = 1: the addressed register is written with `wr_data` (masked fields only).
- Priority, same edge:
  - `TakenInterrupt` overrides an `mtc0` to EPC; EPC gets `next_pc`.
  - `TakenInterrupt` forces EXL = 1 even if `mtc0` Status writes EXL = 0; IM and IE still take `wr_data`.
  - `ERET` and `TakenInterrupt` cannot coincide, because `TakenInterrupt` requires EXL = 0. If `ERET` and `mtc0` Status coincide, `ERET` wins on EXL.
- Reset values:
  - Status = 0: interrupts disabled.
  - EPC = `RESET_EPC`.
  - `TakenInterrupt` = 0.
  - `rd_data` reflects these values while reset is held.

## Timing
- `rd_data`, `EPC`, `TakenInterrupt`: combinational from state plus `TimerInterrupt`/`regnum`; no latency.
- Writes take effect at the rising edge and are visible in the following cycle.
- Interrupt latency: `TimerInterrupt` rising in cycle N with IE = 1, IM[7] = 1 and EXL = 0 gives `TakenInterrupt` = 1 in cycle N. EXL is 1 from cycle N+1, so `TakenInterrupt` is high for exactly one cycle per entry.
- A still-pending `TimerInterrupt` after `eret` (EXL cleared at edge N) re-asserts `TakenInterrupt` in cycle N+1.
- Async reset mid-handler clears EXL and IE immediately; `TakenInterrupt` drops in the same cycle.

## Structure
- Shared header (alongside the existing ALU op defines):
  - register numbers: `CP0_STATUS`, `CP0_CAUSE`, `CP0_EPC`;
  - bit positions: `STATUS_IE` 0, `STATUS_EXL` 1, `IM` field 15:8, `CAUSE_IP7` 15.
- One natural sub-module, `cp0_reg`: a parameterised-width register with enable, active-low async reset and reset value. Instantiate it for EPC (32), IM (8), IE (1) and EXL (1).
- Write-enable and next-value logic stays in the top level.

## Test plan
- Reset hold: drive `reset` = 0 with `TimerInterrupt` = 1. Require `TakenInterrupt` = 0, `rd_data`(12) = 0 and EPC = 0.
- Basic take:
  - Stimulus: `mtc0` Status ← 32'h0000_8001, then `TimerInterrupt` = 1 with `next_pc` = 32'h0040_0024.
  - Required: `TakenInterrupt` = 1 for one cycle; afterwards EPC = 32'h0040_0024 and Status reads 32'h0000_8003.
- Masking:
  - Status ← 32'h0000_0001 with `TimerInterrupt` = 1: require `TakenInterrupt` = 0 and `rd_data`(13) = 32'h0000_8000.
  - Status ← 32'h0000_8000 (IE = 0): require `TakenInterrupt` = 0.
- Eret re-entry: while in the handler, keep `TimerInterrupt` = 1 and pulse `ERET`. Require EXL = 0, then `TakenInterrupt` = 1 on the next cycle with new EPC = `next_pc`.
- Collisions on the same edge as `TakenInterrupt`:
  - `mtc0` EPC ← 32'hDEAD_BEEF: require EPC = `next_pc`.
  - `mtc0` Status ← 32'h0000_FF01: require Status = 32'h0000_FF03.
- Unused registers: `mtc0` to regs 13 and 5 with 32'hFFFF_FFFF. Require no state change, `rd_data`(5) = 0, and Status bits 31:16 and 7:2 read 0 after writing all-ones to Status.
